// File: rtl/simulador_tanques_pkg.sv
// Shared definitions for the two-tank plant model: sensor bit positions and the sensor vector.
// The optional fault override is enabled by SIMULADOR_FALHA_SENSOR_EN.
package simulador_pkg;

  localparam int S_INF_BAIXO = 0;
  localparam int S_INF_ALTO  = 1;
  localparam int S_SUP_BAIXO = 2;
  localparam int S_SUP_ALTO  = 3;
  localparam int N_SENSORES  = 4;

  typedef logic [N_SENSORES-1:0] sensor_t;

  // Replaces each measured bit whose force bit is set with the forced value.
  function automatic sensor_t aplica_forca(sensor_t medido, sensor_t forca, sensor_t valor);
    return (medido & ~forca) | (valor & forca);
  endfunction

endpackage

// File: rtl/simulador_tanques_if.sv
// Plant <-> controller signal bundle. The controller side is master, the plant is slave.
// Fault-injection signals exist only when SIMULADOR_FALHA_SENSOR_EN is defined.
interface simulador_tanques_if
  import simulador_pkg::*;
#(
  parameter int W = 8
) ();

  logic         m1;
  logic         m2;
  logic         consumo;
  logic         s1;
  logic         s2;
  logic         s3;
  logic         s4;
  logic [W-1:0] nivel_inf;
  logic [W-1:0] nivel_sup;
  logic         transbordo;
  logic         bomba_seca;

`ifdef SIMULADOR_FALHA_SENSOR_EN
  sensor_t      forca_sensor;
  sensor_t      valor_forcado;

  modport master (
    output m1, m2, consumo, forca_sensor, valor_forcado,
    input  s1, s2, s3, s4, nivel_inf, nivel_sup, transbordo, bomba_seca
  );

  modport slave (
    input  m1, m2, consumo, forca_sensor, valor_forcado,
    output s1, s2, s3, s4, nivel_inf, nivel_sup, transbordo, bomba_seca
  );
`else
  modport master (
    output m1, m2, consumo,
    input  s1, s2, s3, s4, nivel_inf, nivel_sup, transbordo, bomba_seca
  );

  modport slave (
    input  m1, m2, consumo,
    output s1, s2, s3, s4, nivel_inf, nivel_sup, transbordo, bomba_seca
  );
`endif

endinterface

// File: rtl/simulador_tanques_modelo.sv
// One tank: saturating level register updated on model ticks, plus registered
// low/high threshold sensors that follow the level one clock later.
module modelo_tanque
#(
  parameter int W          = 8,
  parameter int CAPACIDADE = 200,
  parameter int LIM_BAIXO  = 40,
  parameter int LIM_ALTO   = 160,
  parameter int NIVEL_INI  = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick_i,
  input  logic [W:0]   entra_i,
  input  logic [W:0]   sai_i,
  output logic [W-1:0] nivel_o,
  output logic         excede_o,
  output logic         baixo_o,
  output logic         alto_o
);

  localparam logic [W:0] CAP_EXT = (W+1)'(CAPACIDADE);

  logic [W-1:0] nivel_q, nivel_d;
  logic         baixo_q, alto_q;
  logic [W:0]   soma, liquido;

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    soma     = {1'b0, nivel_q} + entra_i;
    liquido  = (soma < sai_i) ? '0 : soma - sai_i;
    excede_o = liquido > CAP_EXT;
    nivel_d  = nivel_q;
    if (tick_i) begin
      nivel_d = excede_o ? W'(CAPACIDADE) : liquido[W-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nivel_q <= W'(NIVEL_INI);
      baixo_q <= (NIVEL_INI >= LIM_BAIXO);
      alto_q  <= (NIVEL_INI >= LIM_ALTO);
    end else begin
      nivel_q <= nivel_d;
      // Sensors sample the current level, giving them one clock of latency.
      baixo_q <= (nivel_q >= W'(LIM_BAIXO));
      alto_q  <= (nivel_q >= W'(LIM_ALTO));
    end
  end

  assign nivel_o = nivel_q;
  assign baixo_o = baixo_q;
  assign alto_o  = alto_q;

endmodule

// File: rtl/simulador_tanques.sv
// Two-tank plant model: prescaler, pump transfer, sticky flags and sensor outputs.
// Defining SIMULADOR_FALHA_SENSOR_EN adds a zero-latency per-sensor force override.
module simulador_tanques
  import simulador_pkg::*;
#(
  parameter int W             = 8,
  parameter int CAPACIDADE    = 200,
  parameter int LIM_BAIXO     = 40,
  parameter int LIM_ALTO      = 160,
  parameter int TAXA_M1       = 4,
  parameter int TAXA_M2       = 3,
  parameter int TAXA_CONSUMO  = 2,
  parameter int PERIODO       = 4,
  parameter int NIVEL_INI_INF = 0,
  parameter int NIVEL_INI_SUP = 0
) (
  input logic                clk,
  input logic                rst_n,
  simulador_tanques_if.slave tanques
);

  localparam int PW = (PERIODO > 1) ? $clog2(PERIODO) : 1;
  localparam logic [W:0] TAXA_M2_EXT = (W+1)'(TAXA_M2);

  logic [PW-1:0] presc_q, presc_d;
  logic          tick;
  logic [W:0]    xfer, in1, saida;
  logic [W-1:0]  nivel_inf, nivel_sup;
  logic          excede_inf, excede_sup, seca;
  logic          transbordo_q, transbordo_d;
  logic          bomba_seca_q, bomba_seca_d;
  sensor_t       sens_medido, sens_final;

  always_comb begin
    tick    = (presc_q == PW'(PERIODO - 1));
    presc_d = tick ? '0 : presc_q + 1'b1;
  end

  // Pump 2 can only move what the lower tank currently holds.
  always_comb begin
    xfer  = '0;
    in1   = '0;
    saida = '0;
    if (tanques.m2) begin
      xfer = ({1'b0, nivel_inf} < TAXA_M2_EXT) ? {1'b0, nivel_inf} : TAXA_M2_EXT;
    end
    if (tanques.m1) begin
      in1 = (W+1)'(TAXA_M1);
    end
    if (tanques.consumo) begin
      saida = (W+1)'(TAXA_CONSUMO);
    end
    seca = tanques.m2 && ({1'b0, nivel_inf} < TAXA_M2_EXT);
  end

  modelo_tanque #(
    .W(W), .CAPACIDADE(CAPACIDADE), .LIM_BAIXO(LIM_BAIXO),
    .LIM_ALTO(LIM_ALTO), .NIVEL_INI(NIVEL_INI_INF)
  ) u_inferior (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_i   (tick),
    .entra_i  (in1),
    .sai_i    (xfer),
    .nivel_o  (nivel_inf),
    .excede_o (excede_inf),
    .baixo_o  (sens_medido[S_INF_BAIXO]),
    .alto_o   (sens_medido[S_INF_ALTO])
  );

  modelo_tanque #(
    .W(W), .CAPACIDADE(CAPACIDADE), .LIM_BAIXO(LIM_BAIXO),
    .LIM_ALTO(LIM_ALTO), .NIVEL_INI(NIVEL_INI_SUP)
  ) u_superior (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_i   (tick),
    .entra_i  (xfer),
    .sai_i    (saida),
    .nivel_o  (nivel_sup),
    .excede_o (excede_sup),
    .baixo_o  (sens_medido[S_SUP_BAIXO]),
    .alto_o   (sens_medido[S_SUP_ALTO])
  );

  // Flags are sticky: once set they hold until reset.
  always_comb begin
    transbordo_d = transbordo_q | (tick & (excede_inf | excede_sup));
    bomba_seca_d = bomba_seca_q | (tick & seca);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      transbordo_q <= 1'b0;
      bomba_seca_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      transbordo_q <= transbordo_d;
      bomba_seca_q <= bomba_seca_d;
    end
  end

`ifdef SIMULADOR_FALHA_SENSOR_EN
  assign sens_final = aplica_forca(sens_medido, tanques.forca_sensor, tanques.valor_forcado);
`else
  assign sens_final = sens_medido;
`endif

  assign tanques.s1         = sens_final[S_INF_BAIXO];
  assign tanques.s2         = sens_final[S_INF_ALTO];
  assign tanques.s3         = sens_final[S_SUP_BAIXO];
  assign tanques.s4         = sens_final[S_SUP_ALTO];
  assign tanques.nivel_inf  = nivel_inf;
  assign tanques.nivel_sup  = nivel_sup;
  assign tanques.transbordo = transbordo_q;
  assign tanques.bomba_seca = bomba_seca_q;

endmodule

// File: doc/simulador_tanques.md
# simulador_tanques

Closed-loop plant model for the pump controller: consumes motor commands `m1`/`m2` and produces the four level-sensor bits `s1`–`s4` the controller reads. Models a lower tank filled by pump 1 and drained by pump 2, and an upper tank filled by pump 2 and drained by a consumption input. Sits opposite `controlador_bombas` in the system testbench and in the FPGA demo. Levels integrate over time; sensors are derived from them.

## Interface
- `W`, 8 — level counter width.
- `CAPACIDADE`, 200 — max level of either tank; must be ≤ 2^W−1.
- `LIM_BAIXO`, 40 — low-sensor threshold (`s1`/`s3`); must be < `LIM_ALTO`.
- `LIM_ALTO`, 160 — high-sensor threshold (`s2`/`s4`).
- `TAXA_M1`, 4 — units added to the lower tank per tick while `m1`=1.
- `TAXA_M2`, 3 — units moved lower→upper per tick while `m2`=1.
- `TAXA_CONSUMO`, 2 — units removed from the upper tank per tick while `consumo`=1.
- `PERIODO`, 4 — clocks per model tick; ≥1.
- `NIVEL_INI_INF`, 0 / `NIVEL_INI_SUP`, 0 — reset levels.

Ports:
- `clk` in 1 — the single clock. All state updates on the rising edge.
- `rst_n` in 1 — reset, asynchronous and active-low.
- `m1`, `m2` in 1 — pump commands.
- `consumo` in 1 — upper-tank draw.
- `s1`, `s2`, `s3`, `s4` out 1 — level sensors: lower low, lower high, upper low, upper high.
- `nivel_inf`, `nivel_sup` out W — current levels.
- `transbordo` out 1 — sticky overflow flag.
- `bomba_seca` out 1 — sticky dry-run flag.
- `forca_sensor` in 4, `valor_forcado` in 4 — present only with `FALHA_SENSOR_EN`. Bit 0 maps to `s1`, bit 3 to `s4`.

## Operation
- Prescaler counts 0..`PERIODO`−1. A tick fires on the cycle the prescaler equals `PERIODO`−1; the prescaler then wraps to 0. With `PERIODO`=1, every cycle is a tick.
- Updates per tick, all computed from pre-tick values with W+1-bit intermediates:
  - xfer = `m2` ? min(`TAXA_M2`, nivel_inf) : 0.
  - in1 = `m1` ? `TAXA_M1` : 0.
  - out = `consumo` ? `TAXA_CONSUMO` : 0.
  - nivel_inf ← min(nivel_inf + in1 − xfer, `CAPACIDADE`).
  - nivel_sup ← clamp(nivel_sup + xfer − out, 0, `CAPACIDADE`).
- Pump 2 moves only what the lower tank holds. Upper-tank spill beyond `CAPACIDADE` is lost.
- `transbordo` sets on a tick where any pre-saturation sum exceeds `CAPACIDADE`.
- `bomba_seca` sets on a tick where `m2`=1 and pre-tick nivel_inf < `TAXA_M2`.
- Both flags clear only on reset.
- Sensors are registered:
  - s1 = nivel_inf ≥ `LIM_BAIXO`; s2 = nivel_inf ≥ `LIM_ALTO`.
  - s3 and s4 are the same comparisons on nivel_sup.
  - Physically impossible codes (low=0, high=1) never arise from the model itself.
- Inputs are sampled only on tick cycles; changes between ticks have no effect.

## Timing
- Reset values:
  - prescaler 0; levels = `NIVEL_INI_*`.
  - `s1`–`s4` = comparisons of the initial levels. Defaults give all 0.
  - `transbordo` = `bomba_seca` = 0.
- First tick occurs on the `PERIODO`-th rising edge after `rst_n` deasserts.
- Level outputs change on the tick edge. Sensors follow one edge later (latency 1). Flags set on the tick edge.
- Reset asserted mid-tick-window aborts the window: prescaler returns to 0 and levels reload.

## Configuration
- `SIMULADOR_FALHA_SENSOR_EN` defined:
  - `forca_sensor`/`valor_forcado` ports exist.
  - Each sensor output with its force bit set equals the matching `valor_forcado` bit, combinationally after the sensor register (0-cycle override).
  - Used to drive the controller's alarm paths.
- Undefined: ports are absent and sensors are purely level-derived.

## Structure
- Package `simulador_pkg`: sensor index constants (`S_INF_BAIXO`=0 … `S_SUP_ALTO`=3) and the sensor-vector typedef.
- Sub-module `modelo_tanque`: one tank's saturating level register, threshold comparators and sensor registers. Instantiated twice. The top holds the prescaler, the transfer computation, the flags and the fault override.

## Test plan
- Defaults, `m1`=1, others 0 → nivel_inf=40 after edge 40; `s1` rises at edge 41; `s2` rises at edge 161.
- nivel_inf=160, `m1`=1 for 20 ticks → nivel_inf saturates at 200; `transbordo`=1 on the tick where 200+4 would exceed capacity.
- `NIVEL_INI_INF`=5, `m2`=1 → ticks move 3, then 2; nivel_sup=5; `bomba_seca`=1 on the second tick.
- `m1`=`m2`=1, both tanks start at 100 → per tick nivel_inf +1, nivel_sup +3.
- `NIVEL_INI_SUP`=1, `consumo`=1 → nivel_sup clamps to 0; no wrap.
- With `SIMULADOR_FALHA_SENSOR_EN`: force bit 1 with value 1 at level 0 → `s2`=1 and `s1`=0 in the same cycle. Releasing the force returns `s2` to 0 immediately.
